// File: rtl/serial_substractor_ctrl_if.sv
// Request/result bus of the bit-serial subtractor controller.
// The master drives operands, start and ack; the slave returns status and result.
interface serial_substractor_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ack;
    logic             ovf;

    modport master (
        output start, a, b, bin, ack,
        input  ready, busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin, ack,
        output ready, busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_substractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module serial_substractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    serial_substractor_ctrl_if.slave   bus
);
    localparam int CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

    stateT            state;
    stateT            nextState;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             borrow;
    logic [CntW-1:0]  cnt;
    logic [WIDTH-1:0] diffQ;
    logic             boutQ;
    logic             lastBit;

    // Shared single-bit full subtractor cell: x - y - z -> D, borrow B.
    logic cellX, cellY, cellZ, dBit, bBit;

    always_comb begin
        cellX = sa[0];
        cellY = sb[0];
        cellZ = borrow;
        dBit  = cellX ^ cellY ^ cellZ;
        bBit  = (~cellX & cellY) | (~(cellX ^ cellY) & cellZ);
    end

    assign lastBit = (cnt == CntW'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    // NOTE: default assignment first keeps this combinational block latch-free.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (bus.start) nextState = RUN;
            RUN:     if (lastBit)   nextState = DONE;
            DONE:    if (bus.ack)   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (state == IDLE);
        bus.busy  = (state == RUN);
        bus.done  = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diffQ  <= '0;
            boutQ  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa     <= bus.a;
                        sb     <= bus.b;
                        borrow <= bus.bin;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    diffQ  <= {dBit, diffQ[WIDTH-1:1]};
                    borrow <= bBit;
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    // Counter stops at WIDTH-1 so it never wraps while running.
                    if (lastBit) boutQ <= bBit;
                    else         cnt   <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.diff = diffQ;
    assign bus.bout = boutQ;

`ifdef SERIAL_SUB_OVF_EN
    logic aMsb;
    logic bMsb;
    logic ovfQ;

    // The final D bit is the result MSB, so overflow is decided on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aMsb <= 1'b0;
            bMsb <= 1'b0;
            ovfQ <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                aMsb <= bus.a[WIDTH-1];
                bMsb <= bus.b[WIDTH-1];
            end
            if (state == RUN && lastBit)
                ovfQ <= (aMsb != bMsb) && (dBit != aMsb);
        end
    end

    assign bus.ovf = ovfQ;
`else
    assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_serial_substractor_ctrl.sv
// Directed bench for serial_substractor_ctrl (WIDTH=8) with hand-computed results.
// Expected ovf follows SERIAL_SUB_OVF_EN as defined for the build.
module tb_serial_substractor_ctrl;
    localparam int WIDTH = 8;
`ifdef SERIAL_SUB_OVF_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   nCmp = 0;
    int   nErr = 0;

    serial_substractor_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_substractor_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Called at accept edge + 1: counts edges until done, checking RUN status meanwhile.
    task automatic waitDone(output int lat, output bit runOk);
        lat   = -1;
        runOk = (bus.busy === 1'b1) && (bus.ready === 1'b0);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
            if (!(bus.busy === 1'b1 && bus.ready === 1'b0)) runOk = 1'b0;
        end
    endtask

    task automatic runOp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic binv, output int lat, output bit runOk);
        for (int k = 0; k < 20 && bus.ready !== 1'b1; k++) begin
            @(posedge clk); #1;
        end
        bus.a = av; bus.b = bv; bus.bin = binv; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        waitDone(lat, runOk);
    endtask

    task automatic doAck();
        bus.ack = 1'b1;
        @(posedge clk); #1;
        bus.ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.ack = 1'b0;
        #12;
        nCmp++;
        if ({bus.ready, bus.busy, bus.done, bus.bout, bus.ovf} !== 5'b10000) begin
            nErr++;
            $display("FAIL reset_status got rdy/busy/done/bout/ovf=%b want 10000",
                     {bus.ready, bus.busy, bus.done, bus.bout, bus.ovf});
        end
        nCmp++;
        if (bus.diff !== 8'h00) begin
            nErr++; $display("FAIL reset_diff got %h want 00", bus.diff);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat; bit runOk;
        runOp(8'd100, 8'd37, 1'b0, lat, runOk);
        nCmp++;
        if (lat !== 8) begin nErr++; $display("FAIL basic_latency got %0d want 8", lat); end
        nCmp++;
        if (runOk !== 1'b1) begin nErr++; $display("FAIL basic_run_status got %b want 1", runOk); end
        nCmp++;
        if (bus.diff !== 8'h3F) begin nErr++; $display("FAIL basic_diff got %h want 3f", bus.diff); end
        nCmp++;
        if (bus.bout !== 1'b0 || bus.ovf !== 1'b0) begin
            nErr++; $display("FAIL basic_flags got bout=%b ovf=%b want 0 0", bus.bout, bus.ovf);
        end
        doAck();
    endtask

    task automatic test_borrow();
        int lat; bit runOk;
        runOp(8'h00, 8'h01, 1'b0, lat, runOk);
        nCmp++;
        if ({bus.diff, bus.bout, bus.ovf} !== {8'hFF, 1'b1, 1'b0}) begin
            nErr++; $display("FAIL borrow_0m1 got diff=%h bout=%b ovf=%b want ff 1 0", bus.diff, bus.bout, bus.ovf);
        end
        doAck();
        runOp(8'h05, 8'h05, 1'b1, lat, runOk);
        nCmp++;
        if ({bus.diff, bus.bout, bus.ovf} !== {8'hFF, 1'b1, 1'b0}) begin
            nErr++; $display("FAIL borrow_bin got diff=%h bout=%b ovf=%b want ff 1 0", bus.diff, bus.bout, bus.ovf);
        end
        doAck();
    endtask

    task automatic test_ovf();
        int lat; bit runOk;
        runOp(8'h80, 8'h01, 1'b0, lat, runOk);
        nCmp++;
        if ({bus.diff, bus.bout, bus.ovf} !== {8'h7F, 1'b0, OvfEn}) begin
            nErr++; $display("FAIL ovf_80m01 got diff=%h bout=%b ovf=%b want 7f 0 %b", bus.diff, bus.bout, bus.ovf, OvfEn);
        end
        doAck();
        runOp(8'h10, 8'h01, 1'b0, lat, runOk);
        nCmp++;
        if ({bus.diff, bus.bout, bus.ovf} !== {8'h0F, 1'b0, 1'b0}) begin
            nErr++; $display("FAIL ovf_10m01 got diff=%h bout=%b ovf=%b want 0f 0 0", bus.diff, bus.bout, bus.ovf);
        end
        doAck();
    endtask

    task automatic test_ignore_start();
        int lat = -1;
        bit stable = 1'b1;
        bus.a = 8'h30; bus.b = 8'h10; bus.bin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = 8'hFF; bus.b = 8'h01; bus.bin = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            bus.start = (k == 3 || k == 5);
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin lat = k; break; end
        end
        nCmp++;
        if (lat !== 8) begin nErr++; $display("FAIL ignore_latency got %0d want 8", lat); end
        nCmp++;
        if (bus.diff !== 8'h20 || bus.bout !== 1'b0) begin
            nErr++; $display("FAIL ignore_result got diff=%h bout=%b want 20 0", bus.diff, bus.bout);
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b1 || bus.diff !== 8'h20 || bus.bout !== 1'b0) stable = 1'b0;
        end
        nCmp++;
        if (stable !== 1'b1) begin nErr++; $display("FAIL hold_stable got %b want 1", stable); end
        doAck();
        nCmp++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
            nErr++; $display("FAIL ack_ready got ready=%b done=%b want 1 0", bus.ready, bus.done);
        end
    endtask

    task automatic test_start_ack_together();
        int lat; bit runOk;
        runOp(8'h09, 8'h03, 1'b0, lat, runOk);
        bus.a = 8'h44; bus.b = 8'h04; bus.bin = 1'b0;
        bus.start = 1'b1; bus.ack = 1'b1;
        @(posedge clk); #1;
        bus.ack = 1'b0;
        nCmp++;
        if ({bus.ready, bus.busy, bus.done} !== 3'b100) begin
            nErr++; $display("FAIL both_to_idle got rdy/busy/done=%b want 100", {bus.ready, bus.busy, bus.done});
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        nCmp++;
        if (bus.busy !== 1'b1) begin nErr++; $display("FAIL held_start_accept got busy=%b want 1", bus.busy); end
        waitDone(lat, runOk);
        nCmp++;
        if (lat !== 8 || bus.diff !== 8'h40 || bus.bout !== 1'b0) begin
            nErr++; $display("FAIL held_start_result got lat=%0d diff=%h bout=%b want 8 40 0", lat, bus.diff, bus.bout);
        end
        doAck();
    endtask

    task automatic test_reset_mid_run();
        int lat; bit runOk;
        bus.a = 8'h77; bus.b = 8'h11; bus.bin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        nCmp++;
        if ({bus.ready, bus.busy, bus.done, bus.bout, bus.ovf, bus.diff} !== {5'b10000, 8'h00}) begin
            nErr++; $display("FAIL async_reset got rdy/busy/done/bout/ovf=%b diff=%h want 10000 00",
                             {bus.ready, bus.busy, bus.done, bus.bout, bus.ovf}, bus.diff);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        nCmp++;
        if (bus.ready !== 1'b1 || bus.diff !== 8'h00) begin
            nErr++; $display("FAIL post_reset_idle got ready=%b diff=%h want 1 00", bus.ready, bus.diff);
        end
        runOp(8'hAA, 8'h55, 1'b0, lat, runOk);
        nCmp++;
        if ({bus.diff, bus.bout, bus.ovf} !== {8'h55, 1'b0, OvfEn}) begin
            nErr++; $display("FAIL post_reset_op got diff=%h bout=%b ovf=%b want 55 0 %b", bus.diff, bus.bout, bus.ovf, OvfEn);
        end
        doAck();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_ovf();
        test_ignore_start();
        test_start_ack_together();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
